// File: rtl/ex_alu_muldiv_if.sv
// Execute-stage operand/result bundle between ID/EX, the ALU/muldiv block and EX/MEM.
interface ex_alu_muldiv_if;
  logic [3:0]  ALUCtl;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_start;
  logic [1:0]  md_op;
  logic        hilo_read;
  logic [31:0] ALUOut;
  logic        Zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_busy;
  logic        stall;

  modport master (output ALUCtl, A, B, md_start, md_op, hilo_read,
                  input  ALUOut, Zero, hi, lo, md_busy, stall);
  modport slave  (input  ALUCtl, A, B, md_start, md_op, hilo_read,
                  output ALUOut, Zero, hi, lo, md_busy, stall);
endinterface

// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU plus HI/LO pair fed by a 32-step iterative multiply/divide engine.
module ex_alu_muldiv (
  input  logic           clk,
  input  logic           rst,
  ex_alu_muldiv_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] a_raw, mag_b, acc, wlo, hi_q, lo_q;
  logic        neg_q, neg_r;
  logic [31:0] alu_r;

  always_comb begin
    alu_r = 32'h0;
    case (bus.ALUCtl)
      4'd0:    alu_r = bus.A & bus.B;
      4'd1:    alu_r = bus.A | bus.B;
      4'd2:    alu_r = bus.A + bus.B;
      4'd6:    alu_r = bus.A - bus.B;
      4'd7:    alu_r = {31'h0, $signed(bus.A) < $signed(bus.B)};
      4'd12:   alu_r = ~(bus.A | bus.B);
      default: alu_r = 32'h0;
    endcase
  end

  assign bus.ALUOut  = alu_r;
  assign bus.Zero    = (alu_r == 32'h0);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.md_busy = (state == RUN);
  assign bus.stall   = bus.md_busy && (bus.md_start || bus.hilo_read);

  // Operand capture: MULT and DIV (md_op 0/2) work on magnitudes.
  logic        is_signed, sa, sb, start_acc, done;
  logic [31:0] mag_a_in, mag_b_in;
  assign is_signed = ~bus.md_op[0];
  assign sa        = is_signed & bus.A[31];
  assign sb        = is_signed & bus.B[31];
  assign mag_a_in  = sa ? -bus.A : bus.A;
  assign mag_b_in  = sb ? -bus.B : bus.B;

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.md_start) begin
        start_acc = 1'b1;
        state_n   = RUN;
      end
      RUN: if (cnt == 5'd31) begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // One iteration; acc holds the running high half (mult) or partial remainder (div).
  logic [32:0] sum, shifted;
  logic        ge;
  logic [31:0] nacc, nwlo;
  always_comb begin
    sum     = {1'b0, acc} + (wlo[0] ? {1'b0, mag_b} : 33'h0);
    shifted = {acc, wlo[31]};
    ge      = (shifted >= {1'b0, mag_b});
    if (op[1]) begin
      nacc = ge ? (shifted[31:0] - mag_b) : shifted[31:0];
      nwlo = {wlo[30:0], ge};
    end else begin
      nacc = sum[32:1];
      nwlo = {sum[0], wlo[31:1]};
    end
  end

  // Sign correction folded into the completing write.
  logic [63:0] prod;
  logic [31:0] fin_hi, fin_lo;
  always_comb begin
    prod = {nacc, nwlo};
    if (neg_q) prod = -prod;
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
    if (op[1]) begin
      if (mag_b == 32'h0) begin
        fin_hi = a_raw;
        fin_lo = 32'hFFFF_FFFF;
      end else begin
        fin_lo = neg_q ? -nwlo : nwlo;
        fin_hi = neg_r ? -nacc : nacc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 5'd0;
      op    <= 2'd0;
      a_raw <= 32'h0;
      mag_b <= 32'h0;
      acc   <= 32'h0;
      wlo   <= 32'h0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
    end else if (start_acc) begin
      cnt   <= 5'd0;
      op    <= bus.md_op;
      a_raw <= bus.A;
      mag_b <= mag_b_in;
      acc   <= 32'h0;
      wlo   <= mag_a_in;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      acc <= nacc;
      wlo <= nwlo;
      if (done) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end
endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Scoreboarded random/directed bench for ex_alu_muldiv against a plain-arithmetic model.
module tb_ex_alu_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_alu_muldiv_if bus ();
  ex_alu_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t q[$];

  int nvec = 0, nerr = 0;
  logic [31:0] ehi = 32'h0, elo = 32'h0;
  bit mon_en = 0, rst_prev = 0, busy_prev = 0;
  int bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sb, p, qq, rr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin up = {32'h0, a} * {32'h0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
      default: begin
        if (b == 32'h0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          qq = sa / sb; rr = sa % sb; r.hi = rr[31:0]; r.lo = qq[31:0];
        end else begin
          r.hi = a % b; r.lo = a / b;
        end
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    if (rst_prev) begin
      q.delete();
      ehi = 32'h0; elo = 32'h0; bcnt = 0; busy_prev = 0;
      chk("rst_busy", {31'h0, bus.md_busy}, 32'h0);
    end else begin
      if (bus.md_busy) bcnt++;
      else if (busy_prev) begin
        chk("busy_len", bcnt, 32);
        bcnt = 0;
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL sb_empty: completion with no expected result");
        end else begin
          e = q.pop_front(); ehi = e.hi; elo = e.lo;
        end
      end
      busy_prev = bus.md_busy;
    end
    chk("hi", bus.hi, ehi);
    chk("lo", bus.lo, elo);
    chk("stall", {31'h0, bus.stall},
        {31'h0, bus.md_busy && (bus.md_start || bus.hilo_read)});
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.md_op = op; bus.A = a; bus.B = b; bus.md_start = 1'b1;
    while (bus.md_busy && n < 200) begin step(); n++; end
    if (n >= 200) begin nvec++; nerr++; $display("FAIL start_timeout: busy never dropped"); end
    @(posedge clk);
    q.push_back(md_ref(op, a, b));
    #1;
    bus.md_start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;
    chk("accept", {31'h0, bus.md_busy}, 32'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.md_busy && n < 200) begin step(); n++; end
    if (n >= 200) begin nvec++; nerr++; $display("FAIL idle_timeout: busy stuck"); end
  endtask

  task automatic alu_chk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input logic wz);
    bus.ALUCtl = c; bus.A = a; bus.B = b; #1;
    chk("aluout", bus.ALUOut, want);
    chk("zero", {31'h0, bus.Zero}, {31'h0, wz});
  endtask

  initial begin
    exp_t e;
    logic [3:0] c;
    logic [31:0] a, b;
    bus.ALUCtl = 4'd0; bus.A = 32'h0; bus.B = 32'h0;
    bus.md_start = 1'b0; bus.md_op = 2'd0; bus.hilo_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy0", {31'h0, bus.md_busy}, 32'h0);
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    mon_en = 1;

    alu_chk(4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    alu_chk(4'd6, 32'd5, 32'd5, 32'h0, 1'b1);
    alu_chk(4'd7, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    alu_chk(4'd12, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    alu_chk(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15)); a = $urandom; b = (i % 5 == 0) ? a : $urandom;
      alu_chk(c, a, b, alu_ref(c, a, b), alu_ref(c, a, b) == 32'h0);
    end

    start_op(2'd0, 32'hFFFF_FFFE, 32'd3); wait_idle();
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF); chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    start_op(2'd1, 32'hFFFF_FFFE, 32'd3); wait_idle();
    chk("multu_hi", bus.hi, 32'h2); chk("multu_lo", bus.lo, 32'hFFFF_FFFA);
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2); wait_idle();
    chk("div_hi", bus.hi, 32'hFFFF_FFFF); chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    start_op(2'd3, 32'd7, 32'd0); wait_idle();
    chk("divz_hi", bus.hi, 32'd7); chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    chk("divovf_hi", bus.hi, 32'h0); chk("divovf_lo", bus.lo, 32'h8000_0000);

    // MULT followed by MFLO: held until the product lands; an ADD in between never stalls.
    start_op(2'd0, 32'h0001_2345, 32'hFFFF_0F0F);
    e = md_ref(2'd0, 32'h0001_2345, 32'hFFFF_0F0F);
    alu_chk(4'd2, 32'd10, 32'd20, 32'd30, 1'b0);
    chk("add_nostall", {31'h0, bus.stall}, 32'h0);
    bus.hilo_read = 1'b1; #1;
    chk("mflo_stall", {31'h0, bus.stall}, 32'h1);
    for (int n = 0; bus.stall && n < 100; n++) step();
    chk("mflo_val", bus.lo, e.lo);
    bus.hilo_read = 1'b0;

    start_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    start_op(2'd2, 32'h8765_4321, 32'h0000_0123);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = {28'h0, 4'($urandom)};
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) step();
      bus.hilo_read = 1'($urandom_range(0, 1));
      start_op(2'($urandom_range(0, 3)), a, b);
      bus.hilo_read = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 40)) step();
    end
    wait_idle();
    bus.hilo_read = 1'b0;

    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("runrst_busy", {31'h0, bus.md_busy}, 32'h0);
    chk("runrst_hi", bus.hi, 32'h0);
    chk("runrst_lo", bus.lo, 32'h0);
    repeat (40) step();
    chk("runrst_nowrite", bus.lo, 32'h0);

    repeat (3) step();
    chk("sb_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
